// File: rtl/mem_pkg.sv
// Shared types and helpers for the burst memory arbiter: FSM states, burst length
// codes, requester ids and the length-code decoder.
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BURST,
    TURN
  } state_e;

  localparam logic [1:0] ACC_1W  = 2'b00;
  localparam logic [1:0] ACC_4W  = 2'b01;
  localparam logic [1:0] ACC_8W  = 2'b10;
  localparam logic [1:0] ACC_16W = 2'b11;

  typedef enum logic {
    REQ_I = 1'b0,
    REQ_D = 1'b1
  } owner_e;

  function automatic logic [4:0] beats(input logic [1:0] acc_size);
    logic [4:0] n;
    case (acc_size)
      ACC_1W:  n = 5'd1;
      ACC_4W:  n = 5'd4;
      ACC_8W:  n = 5'd8;
      default: n = 5'd16;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// Two-way requester picker. MEM_ARB_RR_EN selects round-robin (remembers the last
// winner); otherwise fixed priority with D over I and no state.
module mem_arb_pick
  import mem_pkg::*;
(
`ifdef MEM_ARB_RR_EN
  input  logic   clk,
  input  logic   rst,
  input  logic   take,
`endif
  input  logic   i_req,
  input  logic   d_req,
  output logic   valid,
  output owner_e owner
);

  assign valid = i_req | d_req;

`ifdef MEM_ARB_RR_EN
  owner_e last_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_q <= REQ_I;
    end else if (take) begin
      last_q <= owner;
    end
  end

  // On a tie the requester that did not win last time goes first.
  always_comb begin
    owner = REQ_I;
    if (i_req && d_req) begin
      owner = (last_q == REQ_D) ? REQ_I : REQ_D;
    end else if (d_req) begin
      owner = REQ_D;
    end
  end
`else
  always_comb begin
    owner = d_req ? REQ_D : REQ_I;
  end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates the single-ported burst memory between fetch (I) and data (D). Beats are
// counted locally from the latched length code. Option macro: MEM_ARB_RR_EN.
module mem_arbiter
  import mem_pkg::*;
#(
  parameter int unsigned ADDRESS_SIZE = 32,
  parameter int unsigned DATA_SIZE    = 32,
  parameter int unsigned ACCESS_SIZE  = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_req,
  input  logic [0:ADDRESS_SIZE-1] i_addr,
  input  logic [0:ACCESS_SIZE-1]  i_acc_size,
  output logic                    i_gnt,
  output logic                    i_rvalid,
  output logic                    i_done,
  input  logic                    d_req,
  input  logic                    d_wren,
  input  logic [0:ADDRESS_SIZE-1] d_addr,
  input  logic [0:ACCESS_SIZE-1]  d_acc_size,
  input  logic [0:DATA_SIZE-1]    d_wdata,
  output logic                    d_gnt,
  output logic                    d_beat,
  output logic                    d_done,
  output logic [0:DATA_SIZE-1]    rdata,
  output logic [0:ADDRESS_SIZE-1] mem_addr,
  output logic [0:DATA_SIZE-1]    mem_d_in,
  output logic [0:ACCESS_SIZE-1]  mem_acc_size,
  output logic                    mem_wren,
  output logic                    mem_enable,
  input  logic [0:DATA_SIZE-1]    mem_d_out
);

  state_e                  state_q, state_d;
  owner_e                  owner_q, pick_owner;
  logic                    pick_valid, take;
  logic [3:0]              cnt_q;
  logic                    wren_q;
  logic [0:ACCESS_SIZE-1]  acc_q;
  logic [0:ADDRESS_SIZE-1] addr_q;
  logic                    rd_strobe_q, rd_last_q;
  logic                    in_burst, burst_last, wr_beat;

  assign in_burst   = (state_q == BURST);
  assign burst_last = ({1'b0, cnt_q} == (beats(acc_q) - 5'd1));
  assign take       = (state_q == IDLE) && pick_valid;

  mem_arb_pick u_pick (
`ifdef MEM_ARB_RR_EN
    .clk   (clk),
    .rst   (rst),
    .take  (take),
`endif
    .i_req (i_req),
    .d_req (d_req),
    .valid (pick_valid),
    .owner (pick_owner)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (pick_valid) state_d = BURST;
      BURST:   if (burst_last) state_d = TURN;
      TURN:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Burst context is captured once at grant; requester inputs are ignored afterwards.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner_q     <= REQ_I;
      cnt_q       <= 4'd0;
      wren_q      <= 1'b0;
      acc_q       <= '0;
      addr_q      <= '0;
      rd_strobe_q <= 1'b0;
      rd_last_q   <= 1'b0;
    end else begin
      // Read data appears the cycle after memory samples each beat.
      rd_strobe_q <= in_burst && !wren_q;
      rd_last_q   <= in_burst && burst_last;
      if (take) begin
        owner_q <= pick_owner;
        cnt_q   <= 4'd0;
        if (pick_owner == REQ_D) begin
          addr_q <= d_addr;
          acc_q  <= d_acc_size;
          wren_q <= d_wren;
        end else begin
          addr_q <= i_addr;
          acc_q  <= i_acc_size;
          wren_q <= 1'b0;
        end
      end else if (in_burst) begin
        cnt_q <= burst_last ? 4'd0 : cnt_q + 4'd1;
      end
    end
  end

  assign mem_addr     = addr_q;
  assign mem_acc_size = acc_q;
  assign mem_wren     = wren_q;
  assign rdata        = rd_strobe_q ? mem_d_out : '0;

  always_comb begin
    wr_beat    = in_burst && wren_q;
    i_gnt      = in_burst && (owner_q == REQ_I);
    d_gnt      = in_burst && (owner_q == REQ_D);
    i_rvalid   = rd_strobe_q && (owner_q == REQ_I);
    i_done     = rd_strobe_q && rd_last_q && (owner_q == REQ_I);
    d_beat     = wr_beat || (rd_strobe_q && (owner_q == REQ_D));
    d_done     = (wr_beat && burst_last) || (rd_strobe_q && rd_last_q && (owner_q == REQ_D));
    mem_enable = in_burst && (cnt_q == 4'd0);
    mem_d_in   = wr_beat ? d_wdata : '0;
  end

endmodule
